// File: rtl/pipe_queue_pkg.sv
// Shared constants for the pipeline queues: per-boundary payload widths and default depth.
// Macros let the core top size its four queues without importing anything.
`ifndef PIPE_QUEUE_DEFS
`define PIPE_QUEUE_DEFS
`define PQ_IF_ID_DATA_L 64
`define PQ_ID_EX_DATA_L 156
`define PQ_EX_MA_DATA_L 74
`define PQ_MA_WB_DATA_L 38
`define PQ_ADDR_L       5
`endif

package pipe_queue_pkg;

    localparam int DEF_DATA_L = `PQ_IF_ID_DATA_L;
    localparam int DEF_ADDR_L = `PQ_ADDR_L;

    // Accepted-operation class for one cycle; bit 1 = write, bit 0 = read.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    function automatic op_e op_decode(input logic wr, input logic rd);
        return op_e'({wr, rd});
    endfunction

endpackage

// File: rtl/pipe_queue_ram.sv
// Simple dual-port storage: one write port, one synchronous read port (1-cycle latency).
// No backpressure; the caller guarantees read and write addresses differ when both fire.
module pipe_queue_ram #(
    parameter int DATA_L = 64,
    parameter int ADDR_L = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_L-1:0] waddr,
    input  logic [DATA_L-1:0] wdat,
    input  logic              re,
    input  logic [ADDR_L-1:0] raddr,
    output logic [DATA_L-1:0] rdat
);

    localparam int DEPTH = 2 ** ADDR_L;

    logic [DATA_L-1:0] mem [DEPTH];

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdat;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdat <= '0;
        else if (re)
            rdat <= mem[raddr];
    end

endmodule

// File: rtl/pipe_queue.sv
// Inter-stage queue with flush, occupancy, almost-full and sticky error flags; 1-cycle write-to-readable.
// Requests are rejected (never stalled) when full/empty; rejections set ovf/udf.
module pipe_queue
    import pipe_queue_pkg::*;
#(
    parameter int DATA_L = DEF_DATA_L,
    parameter int ADDR_L = DEF_ADDR_L,
    parameter int AF_TH  = 2 ** ADDR_L - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              we,
    input  logic [DATA_L-1:0] din,
    output logic              wack,
    input  logic              re,
    output logic [DATA_L-1:0] dout,
    output logic              rack,
    output logic              av,
    output logic              fu,
    output logic              afull,
    output logic [ADDR_L:0]   cnt,
    output logic              ovf,
    output logic              udf
);

    localparam logic [ADDR_L:0] DEPTH_C = (ADDR_L+1)'(2 ** ADDR_L);
    localparam logic [ADDR_L:0] AF_C    = (ADDR_L+1)'(AF_TH);

    logic [ADDR_L-1:0] wp;
    logic [ADDR_L-1:0] rp;
    logic              wr_ok;
    logic              rd_ok;

    assign av    = (cnt != '0);
    assign fu    = (cnt == DEPTH_C);
    assign afull = (cnt >= AF_C);

    // Acceptance uses registered status only, so an empty queue never bypasses.
    assign wr_ok = we & ~fu & ~flush;
    assign rd_ok = re & av & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            wack <= 1'b0;
            rack <= 1'b0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else begin
            wack <= wr_ok;
            rack <= rd_ok;
            ovf  <= ovf | (we & fu & ~flush);
            udf  <= udf | (re & ~av & ~flush);
            if (flush) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (wr_ok)
                    wp <= wp + 1'b1;
                if (rd_ok)
                    rp <= rp + 1'b1;
                case (op_decode(wr_ok, rd_ok))
                    OP_WR:   cnt <= cnt + 1'b1;
                    OP_RD:   cnt <= cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    pipe_queue_ram #(
        .DATA_L (DATA_L),
        .ADDR_L (ADDR_L)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wp),
        .wdat  (din),
        .re    (rd_ok),
        .raddr (rp),
        .rdat  (dout)
    );

endmodule
